regfile_2w2r: RTL
=================

REGFILE_2W2R -- requirements
Module: regfile_2w2r

Interface
REQ-001 Parameter DATA_W, default 16: register width in bits.
REQ-002 Parameter ADDR_W, default 4: address width; depth = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 0: when 1, register 0 always reads 0 and ignores writes and reserves.
REQ-004 CLK  input  1  clock; all state updates on the rising edge.
REQ-005 RSTn  input  1  reset; asynchronous, active-low.
REQ-006 Addr_A  input  ADDR_W  read port A address.
REQ-007 Addr_B  input  ADDR_W  read port B address.
REQ-008 Src  output  DATA_W  registered read data, port A.
REQ-009 Dest  output  DATA_W  registered read data, port B.
REQ-010 WR0 / WAddr0 / WData0  input  1 / ADDR_W / DATA_W  write port 0 enable, address and data.
REQ-011 WR1 / WAddr1 / WData1  input  1 / ADDR_W / DATA_W  write port 1 enable, address and data.
REQ-012 Rsv / Rsv_Addr  input  1 / ADDR_W  scoreboard reserve strobe and target address.
REQ-013 Busy_A / Busy_B  output  1  registered busy bits of the registers addressed by Addr_A and Addr_B.

Function
REQ-014 Read latency SHALL be 1 cycle: Src, Dest, Busy_A and Busy_B SHALL reflect the addresses sampled at the previous rising edge.
REQ-015 A write SHALL commit at the rising edge where its WRx is 1.
REQ-016 When WR0 and WR1 are both 1 with equal addresses, port 1 data SHALL be stored and port 0 data discarded.
REQ-017 A Rsv pulse SHALL set busy[Rsv_Addr] at the rising edge.
REQ-018 A committed write SHALL clear the busy bit of its target register.
REQ-019 When a reserve and a write target the same address in the same cycle, the reserve SHALL win and the busy bit SHALL stay 1; the write data SHALL still commit.
REQ-020 Reads of unwritten registers SHALL return 0; reading and writing the same address on both ports in one cycle SHALL be legal.
REQ-021 With ZERO_REG=1, address 0 SHALL return data 0 and busy 0 regardless of writes or reserves.

Reset
REQ-022 While RSTn=0, the following SHALL be held at 0 immediately and independently of CLK: all registers, all busy bits, Src, Dest, Busy_A and Busy_B.
REQ-023 Writes and reserves presented while RSTn=0 SHALL be discarded.
REQ-024 The first edge after RSTn rises SHALL operate normally.

Configuration
REQ-025 When macro REGFILE_BYPASS_EN is defined, a read whose address matches a write committing in the same cycle SHALL return the new data, and the busy result SHALL reflect REQ-018/REQ-019.
- When both write ports hit the read address, port 1 data SHALL be returned.
REQ-026 When REGFILE_BYPASS_EN is undefined, such a read SHALL return the pre-write value and the pre-write busy bit.

Verification
REQ-027 Reset: RSTn=0 for 20 ns mid-write of 16'h1234 to R1 -> Src=Dest=0 immediately; R1 later reads 16'h0000.
REQ-028 Dual-write conflict: WR0 (R7, 16'hAAAA) and WR1 (R7, 16'h5678) in one cycle -> Addr_A=7 reads 16'h5678 one cycle later.
REQ-029 Two-port read: R1=16'h1234 and R7=16'h5678, then Addr_A=7 and Addr_B=1 -> next cycle Src=16'h5678, Dest=16'h1234; Addr_A=4 and Addr_B=5 -> Src=Dest=0.
REQ-030 Scoreboard, step 1: Rsv to R3 -> Busy_A=1 with Addr_A=3.
- Step 2: WR0 to R3 with 16'h00FF -> Busy_A=0.
- Step 3: Rsv and WR1 to R3 in the same cycle -> Busy_A=1 and R3=WR1 data.
REQ-031 Bypass: R5=16'h1111, then WR0 (R5, 16'h2222) with Addr_A=5 in the same cycle -> next cycle Src=16'h2222 with REGFILE_BYPASS_EN defined, and 16'h1111 without it.
REQ-032 ZERO_REG=1: WR0 (R0, 16'hFFFF) and Rsv to R0 -> Src=0 and Busy_A=0 with Addr_A=0.

Source files
------------

// File: rtl/regfile_2w2r.sv
// regfile_2w2r: 2-write / 2-read register file with a per-register busy scoreboard.
//
// Ports:
//   CLK, RSTn              clock (rising edge) and asynchronous active-low reset
//   Addr_A, Addr_B         read addresses, sampled every rising edge
//   Src, Dest              registered read data for ports A and B (1-cycle latency)
//   Busy_A, Busy_B         registered busy bits of the registers read on A and B
//   WR0/WAddr0/WData0      write port 0
//   WR1/WAddr1/WData1      write port 1 (wins over port 0 on an address clash)
//   Rsv/Rsv_Addr           reserve strobe; sets the busy bit of Rsv_Addr
//
// Parameters:
//   DATA_W    register width
//   ADDR_W    address width, depth = 2**ADDR_W
//   ZERO_REG  when nonzero, register 0 reads as 0, is never busy and ignores writes/reserves
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a read that hits a same-cycle write/reserve returns
//                      the post-update data and busy bit; otherwise the pre-update values.
module regfile_2w2r #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [ADDR_W-1:0] Addr_A,
  input  logic [ADDR_W-1:0] Addr_B,
  output logic [DATA_W-1:0] Src,
  output logic [DATA_W-1:0] Dest,
  input  logic              WR0,
  input  logic [ADDR_W-1:0] WAddr0,
  input  logic [DATA_W-1:0] WData0,
  input  logic              WR1,
  input  logic [ADDR_W-1:0] WAddr1,
  input  logic [DATA_W-1:0] WData1,
  input  logic              Rsv,
  input  logic [ADDR_W-1:0] Rsv_Addr,
  output logic              Busy_A,
  output logic              Busy_B
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic              we0;
  logic              we1;
  logic              rsv_en;
  logic [DATA_W-1:0] src_next;
  logic [DATA_W-1:0] dest_next;
  logic              busy_a_next;
  logic              busy_b_next;

  // Register 0 is hard-wired when ZERO_REG is set, so its writes and
  // reserves are simply never enabled.
  assign we0    = WR0 && !(ZERO_EN && (WAddr0 == '0));
  assign we1    = WR1 && !(ZERO_EN && (WAddr1 == '0));
  assign rsv_en = Rsv && !(ZERO_EN && (Rsv_Addr == '0));

  // Storage and scoreboard. Port 1 is written after port 0 so it wins an
  // address clash; the reserve is applied after the write clears so a
  // same-cycle reserve leaves the register busy.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (we0) begin
        regs[WAddr0] <= WData0;
        busy[WAddr0] <= 1'b0;
      end
      if (we1) begin
        regs[WAddr1] <= WData1;
        busy[WAddr1] <= 1'b0;
      end
      if (rsv_en) begin
        busy[Rsv_Addr] <= 1'b1;
      end
    end
  end

  // Next read values: the stored contents, optionally overridden by the
  // updates committing at this same edge, with register 0 forced to zero.
  always_comb begin
    src_next    = regs[Addr_A];
    dest_next   = regs[Addr_B];
    busy_a_next = busy[Addr_A];
    busy_b_next = busy[Addr_B];
`ifdef REGFILE_BYPASS_EN
    if (we0 && (WAddr0 == Addr_A)) begin
      src_next    = WData0;
      busy_a_next = 1'b0;
    end
    if (we1 && (WAddr1 == Addr_A)) begin
      src_next    = WData1;
      busy_a_next = 1'b0;
    end
    if (rsv_en && (Rsv_Addr == Addr_A)) begin
      busy_a_next = 1'b1;
    end
    if (we0 && (WAddr0 == Addr_B)) begin
      dest_next   = WData0;
      busy_b_next = 1'b0;
    end
    if (we1 && (WAddr1 == Addr_B)) begin
      dest_next   = WData1;
      busy_b_next = 1'b0;
    end
    if (rsv_en && (Rsv_Addr == Addr_B)) begin
      busy_b_next = 1'b1;
    end
`endif
    if (ZERO_EN && (Addr_A == '0)) begin
      src_next    = '0;
      busy_a_next = 1'b0;
    end
    if (ZERO_EN && (Addr_B == '0)) begin
      dest_next   = '0;
      busy_b_next = 1'b0;
    end
  end

  // Registered read outputs, giving the one-cycle read latency.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Src    <= '0;
      Dest   <= '0;
      Busy_A <= 1'b0;
      Busy_B <= 1'b0;
    end else begin
      Src    <= src_next;
      Dest   <= dest_next;
      Busy_A <= busy_a_next;
      Busy_B <= busy_b_next;
    end
  end

endmodule
